// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit writing the HI/LO registers.
// Radix-2 Booth multiply and restoring divide, one step per clock over WIDTH steps.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   // state | meaning
   // IDLE  | waiting for start_mult / start_div
   // MULT  | Booth iterations, work = {P, Q, q-1}
   // DIV   | restoring iterations, work = {remainder, quotient, 0}
   // DONE  | one-cycle done pulse (result written or divide by zero)
   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   localparam logic [5:0] LAST = 6'(WIDTH - 1);

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [64:0] work_q;
   logic [31:0] m_q;
   logic        sa_q, sb_q;
   logic [31:0] hi_q, lo_q;
   logic        busy_q, done_q, dz_q;

   logic [32:0] booth_sum;
   logic [64:0] mult_d;
   logic [32:0] rem_sh, trial;
   logic [64:0] div_d;
   logic [31:0] quo_fix_d, rem_fix_d;
   logic [31:0] abs_a, abs_b;

   always_comb begin
      abs_a = a_in[31] ? (~a_in + 32'd1) : a_in;
      abs_b = b_in[31] ? (~b_in + 32'd1) : b_in;

      // P is sign-extended to 33 bits so P - M cannot overflow when M = -2^31
      booth_sum = {work_q[64], work_q[64:33]};
      case (work_q[1:0])
         2'b01:   booth_sum = booth_sum + {m_q[31], m_q};
         2'b10:   booth_sum = booth_sum - {m_q[31], m_q};
         default: booth_sum = booth_sum;
      endcase
      mult_d = {booth_sum, work_q[32:1]};

      rem_sh = {work_q[64:33], work_q[32]};
      trial  = rem_sh - {1'b0, m_q};
      if (!trial[32]) div_d = {trial[31:0],  work_q[31:1], 1'b1, 1'b0};
      else            div_d = {rem_sh[31:0], work_q[31:1], 1'b0, 1'b0};

      quo_fix_d = (sa_q ^ sb_q) ? (~div_d[32:1] + 32'd1) : div_d[32:1];
      rem_fix_d = sa_q ? (~div_d[64:33] + 32'd1) : div_d[64:33];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         m_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               dz_q   <= 1'b0;
               if (start_mult) begin
                  state_q <= MULT;
                  cnt_q   <= '0;
                  work_q  <= {32'd0, b_in, 1'b0};
                  m_q     <= a_in;
                  busy_q  <= 1'b1;
               end else if (start_div && b_in == 32'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  dz_q    <= 1'b1;
               end else if (start_div) begin
                  state_q <= DIV;
                  cnt_q   <= '0;
                  work_q  <= {32'd0, abs_a, 1'b0};
                  m_q     <= abs_b;
                  sa_q    <= a_in[31];
                  sb_q    <= b_in[31];
                  busy_q  <= 1'b1;
               end
            end
            MULT: begin
               work_q <= mult_d;
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == LAST) begin
                  hi_q    <= mult_d[64:33];
                  lo_q    <= mult_d[32:1];
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DIV: begin
               work_q <= div_d;
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == LAST) begin
                  hi_q    <= rem_fix_d;
                  lo_q    <= quo_fix_d;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               dz_q    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/div_zero,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset, start_mult, start_div;
   logic [31:0] a_in, b_in;
   logic        busy, done, div_zero;
   logic [31:0] hi_out, lo_out;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .div_zero(div_zero),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] hi_m = 0, lo_m = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("hi_out", {32'd0, hi_out}, {32'd0, e.hi});
            check("lo_out", {32'd0, lo_out}, {32'd0, e.lo});
            check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
         end
      end
   end

   // Reference model from the arithmetic definition of mult/div
   function automatic exp_t model(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      e.dz = 1'b0;
      if (sm) begin
         p = 64'($signed(a) * $signed(b));
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (b == 32'd0) begin
         e.dz = 1'b1;
         e.hi = hi_m;
         e.lo = lo_m;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.hi = 32'd0;
         e.lo = 32'h8000_0000;
      end else begin
         e.lo = 32'($signed(a) / $signed(b));
         e.hi = 32'($signed(a) % $signed(b));
      end
      if (!sd && !sm) e = '0;
      return e;
   endfunction

   task automatic run_op(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input bit inject_div);
      exp_t e;
      int   cyc;
      bit   seen;
      e = model(sm, sd, a, b);
      sb_q.push_back(e);
      hi_m = e.hi;
      lo_m = e.lo;
      @(negedge clk);
      start_mult = sm;
      start_div  = sd;
      a_in = a;
      b_in = b;
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a_in = $urandom;
      b_in = $urandom;
      cyc  = 0;
      seen = 0;
      while (cyc < 100 && !seen) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("busy_after_start", {63'd0, busy}, {63'd0, !e.dz});
         if (inject_div) start_div = (cyc == 10);
         if (done) seen = 1;
      end
      start_div = 1'b0;
      check("done_latency", 64'(cyc), e.dz ? 64'd1 : 64'd33);
   endtask

   task automatic reset_dut(input int cycles);
      @(negedge clk);
      reset = 1'b1;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
      hi_m = 0;
      lo_m = 0;
   endtask

   initial begin
      reset = 1'b1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a_in = '0;
      b_in = '0;
      reset_dut(2);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_dz", {63'd0, div_zero}, 64'd0);
      check("reset_hilo", {hi_out, lo_out}, 64'd0);

      run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0);
      run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(1, 0, 32'd3, 32'd5, 0);
      run_op(0, 1, 32'd1234, 32'd0, 0);
      check("dz_preserve", {hi_out, lo_out}, {32'd0, 32'd15});
      run_op(1, 0, 32'h1234_5678, 32'hF00D_CAFE, 1);
      run_op(1, 1, 32'hFFFF_FF00, 32'd77, 0);
      run_op(0, 1, 32'd100, 32'hFFFF_FFF9, 0);

      // Abort a divide with reset at cycle 20
      @(negedge clk);
      start_div = 1'b1;
      a_in = 32'd999_999;
      b_in = 32'd7;
      @(posedge clk);
      #1;
      start_div = 1'b0;
      repeat (20) @(negedge clk);
      reset_dut(1);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hilo", {hi_out, lo_out}, 64'd0);
      repeat (40) @(negedge clk);
      run_op(0, 1, 32'd999_999, 32'd7, 0);

      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         int          k;
         k = $urandom_range(0, 3);
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(0, 3)) - 32'd1;
         case (k)
            0: run_op(1, 0, a, b, 0);
            1: run_op(0, 1, a, b, 0);
            2: run_op(0, 1, a, 32'd0, 0);
            default: run_op(1, 1, a, b, $urandom_range(0, 1) == 1);
         endcase
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
